fetch_pc_unit: RTL and testbench
================================

FETCH_PC_UNIT -- requirements
Module: fetch_pc_unit

Interface
REQ-001 Parameter ADDR_W, default 8: PC and target width in bits.
REQ-002 Parameter NUM_SRC, default 4: number of redirect sources, 1..8.
REQ-003 Parameter PC_INC, default 4: sequential increment, a power of two.
REQ-004 Parameter RESET_PC, default 0: PC value loaded on reset.
REQ-005 Port clk  input  1: single clock, rising edge.
REQ-006 Port reset_n  input  1: asynchronous, active-low reset.
REQ-007 Port src_pc  input  NUM_SRC*ADDR_W: packed redirect targets, source i in bits [i*ADDR_W +: ADDR_W].
REQ-008 Port src_valid  input  NUM_SRC: redirect request per source.
REQ-009 Port stall  input  1: holds the PC when high.
REQ-010 Port pc_out  output  ADDR_W: current fetch PC, registered.
REQ-011 Port redirect_taken  output  1: one-cycle pulse, registered; high in the cycle after pc_out was loaded from a redirect.
REQ-012 Port redirect_pending  output  1: high while a captured redirect waits for stall to drop.
REQ-013 Port misalign_err  output  1: sticky alignment-error flag (see Configuration).

Function
REQ-014 Source priority is fixed; the highest asserted index wins. Lower-index targets in the same cycle are discarded.
REQ-015 The FSM SHALL have two states, RUN and HOLD_REDIR.
REQ-016 RUN, stall=0, any src_valid: pc_out <= winning target; redirect_taken <= 1.
REQ-017 RUN, stall=0, no src_valid: pc_out <= pc_out + PC_INC, modulo 2^ADDR_W. The maximum PC wraps to 0 with no flag.
REQ-018 RUN, stall=1, no src_valid: pc_out holds; state stays RUN.
REQ-019 RUN, stall=1, any src_valid: the winning target is captured in the one-entry pending register; pc_out holds; next state is HOLD_REDIR; redirect_pending <= 1.
REQ-020 HOLD_REDIR, stall=1, new src_valid: the pending register is overwritten by the new winner, so the newest redirect wins.
REQ-021 HOLD_REDIR, stall=0, no src_valid: pc_out <= pending target; redirect_taken <= 1; redirect_pending <= 0; next state is RUN.
REQ-022 HOLD_REDIR, stall=0, any src_valid: pc_out <= the live winner; the pending target is dropped; redirect_taken <= 1; next state is RUN.
REQ-023 redirect_taken is 0 in every cycle not covered by REQ-016, REQ-021 or REQ-022.
REQ-024 A redirect is applied with 1-cycle latency: the request is sampled at edge N and is visible on pc_out after edge N.

Reset
REQ-025 While reset_n=0, the block SHALL drive: pc_out=RESET_PC, state=RUN, pending register=0, redirect_taken=0, redirect_pending=0, misalign_err=0.
REQ-026 Reset asserted mid-operation, including in HOLD_REDIR, discards any pending redirect immediately, without waiting for a clock edge.
REQ-027 On the first edge after reset_n rises, the normal rules of REQ-016 to REQ-022 apply.

Configuration
REQ-028 Macro FETCH_PC_ALIGN_CHECK_EN, when defined, SHALL enable the alignment check: any target loaded into pc_out or into the pending register with a nonzero value in bits [log2(PC_INC)-1:0] sets misalign_err. The flag stays set until reset. The target is still used unmodified.
REQ-029 With FETCH_PC_ALIGN_CHECK_EN undefined, misalign_err SHALL be tied to 0 and no check logic is built.

Structure
REQ-030 Shared package fetch_pkg SHALL hold the state enum (RUN, HOLD_REDIR) and the default values of ADDR_W, PC_INC and RESET_PC.
REQ-031 Sub-module fetch_pc_prio_mux SHALL implement the combinational priority select. Inputs: src_pc, src_valid. Outputs: winner target and any_valid.

Verification
REQ-032 Reset release, ADDR_W=8, PC_INC=4, stall=0 -> pc_out sequence 0x00, 0x04, 0x08, 0x0C.
REQ-033 pc_out=0xFC, no redirect -> next pc_out=0x00; redirect_taken=0.
REQ-034 Same cycle: src_valid=4'b0101, src_pc[2]=0x40, src_pc[0]=0x80 -> next pc_out=0x40; redirect_taken pulses for one cycle.
REQ-035 stall=1, redirect to 0x20, then redirect to 0x30 two cycles later, stall drops a cycle after that -> redirect_pending high from the first capture; pc_out held; then pc_out=0x30.
REQ-036 In HOLD_REDIR with pending 0x20, pulse reset_n low between edges -> pc_out=0x00 and redirect_pending=0 immediately; after release, counting restarts from 0x00.
REQ-037 With FETCH_PC_ALIGN_CHECK_EN defined, redirect to 0x22 -> pc_out=0x22; misalign_err=1 and stays set. With the macro undefined, misalign_err=0 throughout.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and default parameter values for the fetch PC unit.
package fetch_pkg;

   localparam int FETCH_ADDR_W   = 8;
   localparam int FETCH_PC_INC   = 4;
   localparam int FETCH_RESET_PC = 0;

   typedef enum logic {
      RUN        = 1'b0,
      HOLD_REDIR = 1'b1
   } state_e;

endpackage

// File: rtl/fetch_pc_prio_mux.sv
// Combinational fixed-priority redirect select: highest asserted source index wins.
module fetch_pc_prio_mux
   import fetch_pkg::*;
#(
   parameter int ADDR_W  = FETCH_ADDR_W,
   parameter int NUM_SRC = 4
) (
   input  logic [NUM_SRC*ADDR_W-1:0] src_pc,
   input  logic [NUM_SRC-1:0]        src_valid,
   output logic [ADDR_W-1:0]         winner,
   output logic                      any_valid
);

   // Ascending scan so a later (higher) index overrides any lower one.
   always_comb begin
      winner    = '0;
      any_valid = 1'b0;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (src_valid[i]) begin
            winner    = src_pc[i*ADDR_W +: ADDR_W];
            any_valid = 1'b1;
         end
      end
   end

endmodule

// File: rtl/fetch_pc_unit.sv
// Fetch PC register with prioritized redirects and a one-entry pending redirect held across stalls.
// Optional alignment check enabled by defining FETCH_PC_ALIGN_CHECK_EN.
module fetch_pc_unit
   import fetch_pkg::*;
#(
   parameter int ADDR_W   = FETCH_ADDR_W,
   parameter int NUM_SRC  = 4,
   parameter int PC_INC   = FETCH_PC_INC,
   parameter int RESET_PC = FETCH_RESET_PC
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic [NUM_SRC*ADDR_W-1:0] src_pc,
   input  logic [NUM_SRC-1:0]        src_valid,
   input  logic                      stall,
   output logic [ADDR_W-1:0]         pc_out,
   output logic                      redirect_taken,
   output logic                      redirect_pending,
   output logic                      misalign_err,
   output state_e                    state_dbg
);

   // Handshake: src_valid is a request with no ready; it is consumed on the edge
   // where it is sampled, either into pc_out (stall low) or into the pending
   // register (stall high), where a newer request replaces an older one.

   logic [ADDR_W-1:0] winner;
   logic              any_valid;

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [ADDR_W-1:0] pend_q, pend_d;
   logic              taken_q, taken_d;

   fetch_pc_prio_mux #(
      .ADDR_W  (ADDR_W),
      .NUM_SRC (NUM_SRC)
   ) u_prio_mux (
      .src_pc    (src_pc),
      .src_valid (src_valid),
      .winner    (winner),
      .any_valid (any_valid)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= RUN;
         pc_q    <= ADDR_W'(RESET_PC);
         pend_q  <= '0;
         taken_q <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         pend_q  <= pend_d;
         taken_q <= taken_d;
      end
   end

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      pend_d  = pend_q;
      taken_d = 1'b0;
      case (state_q)
         RUN: begin
            if (!stall) begin
               if (any_valid) begin
                  pc_d    = winner;
                  taken_d = 1'b1;
               end else begin
                  pc_d = pc_q + ADDR_W'(PC_INC);
               end
            end else if (any_valid) begin
               pend_d  = winner;
               state_d = HOLD_REDIR;
            end
         end
         HOLD_REDIR: begin
            if (!stall) begin
               // A live request in the release cycle supersedes the parked one.
               pc_d    = any_valid ? winner : pend_q;
               pend_d  = '0;
               taken_d = 1'b1;
               state_d = RUN;
            end else if (any_valid) begin
               pend_d = winner;
            end
         end
         default: begin
            state_d = RUN;
            pend_d  = '0;
         end
      endcase
   end

   assign pc_out           = pc_q;
   assign redirect_taken   = taken_q;
   assign redirect_pending = (state_q == HOLD_REDIR);
   assign state_dbg        = state_q;

`ifdef FETCH_PC_ALIGN_CHECK_EN
   localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(PC_INC - 1);
   logic err_q;

   // Every sampled winner lands in pc_out or the pending register, so checking
   // the winner covers both load paths.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         err_q <= 1'b0;
      end else if (any_valid && ((winner & ALIGN_MASK) != '0)) begin
         err_q <= 1'b1;
      end
   end

   assign misalign_err = err_q;
`else
   assign misalign_err = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Bench for fetch_pc_unit: directed literal checks plus randomized traffic against a behavioural model.
module tb_fetch_pc_unit;
   import fetch_pkg::*;

   localparam int AW = 8;
   localparam int NS = 4;
   localparam int INC = 4;
`ifdef FETCH_PC_ALIGN_CHECK_EN
   localparam logic ERR_ON = 1'b1;
`else
   localparam logic ERR_ON = 1'b0;
`endif

   logic           clk = 1'b0;
   logic           reset_n;
   logic [NS*AW-1:0] src_pc;
   logic [NS-1:0]  src_valid;
   logic           stall;
   logic [AW-1:0]  pc_out;
   logic           redirect_taken;
   logic           redirect_pending;
   logic           misalign_err;
   state_e         state_dbg;

   int checks = 0;
   int failures = 0;
   bit chk_en = 1'b0;

   // model state
   int            m_pc;
   logic          m_taken;
   logic          m_err;
   logic [AW-1:0] exp_q[$];

   fetch_pc_unit #(.ADDR_W(AW), .NUM_SRC(NS), .PC_INC(INC), .RESET_PC(0)) dut (
      .clk              (clk),
      .reset_n          (reset_n),
      .src_pc           (src_pc),
      .src_valid        (src_valid),
      .stall            (stall),
      .pc_out           (pc_out),
      .redirect_taken   (redirect_taken),
      .redirect_pending (redirect_pending),
      .misalign_err     (misalign_err),
      .state_dbg        (state_dbg)
   );

   // ---------------- clock/reset ----------------
   always #5 clk = ~clk;

   // ---------------- helpers ----------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int winner_idx(input logic [NS-1:0] v);
      for (int i = NS - 1; i >= 0; i--) if (v[i]) return i;
      return -1;
   endfunction

   task automatic set_src(input int idx, input logic [AW-1:0] tgt);
      src_pc[idx*AW +: AW] = tgt;
   endtask

   // ---------------- behavioural model ----------------
   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         m_pc = 0;
         m_taken = 1'b0;
         m_err = 1'b0;
         exp_q.delete();
      end else begin
         int w;
         logic [AW-1:0] tgt;
         w = winner_idx(src_valid);
         tgt = (w >= 0) ? src_pc[w*AW +: AW] : '0;
         m_taken = 1'b0;
         if (!stall) begin
            if (w >= 0) begin
               m_pc = tgt;
               m_taken = 1'b1;
               exp_q.delete();
            end else if (exp_q.size() != 0) begin
               m_pc = exp_q.pop_front();
               m_taken = 1'b1;
            end else begin
               m_pc = (m_pc + INC) % (1 << AW);
            end
         end else if (w >= 0) begin
            exp_q.delete();
            exp_q.push_back(tgt);
         end
         if (ERR_ON && w >= 0 && (tgt % INC) != 0) m_err = 1'b1;
      end
   end

   // ---------------- scoreboard compare ----------------
   always @(negedge clk) begin
      if (chk_en) begin
         check("sb_pc", pc_out, m_pc);
         check("sb_taken", redirect_taken, m_taken);
         check("sb_pending", redirect_pending, exp_q.size() != 0);
         check("sb_err", misalign_err, m_err);
         check("sb_state", state_dbg, (exp_q.size() != 0) ? HOLD_REDIR : RUN);
      end
   end

   // ---------------- driver / directed + random ----------------
   initial begin
      reset_n = 1'b0;
      stall = 1'b0;
      src_valid = '0;
      src_pc = '0;
      #1;
      check("rst_pc", pc_out, 32'h00);
      check("rst_taken", redirect_taken, 0);
      check("rst_pending", redirect_pending, 0);
      check("rst_err", misalign_err, 0);
      @(negedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      chk_en = 1'b1;

      // sequential counting after reset
      check("seq0", pc_out, 32'h00);
      @(negedge clk); check("seq1", pc_out, 32'h04);
      @(negedge clk); check("seq2", pc_out, 32'h08);
      @(negedge clk); check("seq3", pc_out, 32'h0C);

      // wrap at top of address space
      repeat (60) @(negedge clk);
      check("pre_wrap", pc_out, 32'hFC);
      @(negedge clk);
      check("wrap_pc", pc_out, 32'h00);
      check("wrap_taken", redirect_taken, 0);

      // same-cycle priority: index 2 beats index 0
      set_src(2, 8'h40);
      set_src(0, 8'h80);
      src_valid = 4'b0101;
      @(negedge clk);
      check("prio_pc", pc_out, 32'h40);
      check("prio_taken", redirect_taken, 1);
      src_valid = '0;
      @(negedge clk);
      check("prio_taken_drop", redirect_taken, 0);
      check("prio_next", pc_out, 32'h44);

      // stalled redirects: newest parked target wins
      stall = 1'b1;
      set_src(1, 8'h20);
      src_valid = 4'b0010;
      @(negedge clk);
      check("hold_pend1", redirect_pending, 1);
      check("hold_pc1", pc_out, 32'h44);
      src_valid = '0;
      @(negedge clk);
      check("hold_pc2", pc_out, 32'h44);
      set_src(3, 8'h30);
      src_valid = 4'b1000;
      @(negedge clk);
      check("hold_pend3", redirect_pending, 1);
      check("hold_pc3", pc_out, 32'h44);
      stall = 1'b0;
      src_valid = '0;
      @(negedge clk);
      check("release_pc", pc_out, 32'h30);
      check("release_taken", redirect_taken, 1);
      check("release_pend", redirect_pending, 0);

      // async reset while holding a pending redirect
      stall = 1'b1;
      set_src(1, 8'h20);
      src_valid = 4'b0010;
      @(negedge clk);
      check("pre_rst_pend", redirect_pending, 1);
      src_valid = '0;
      #2 reset_n = 1'b0;
      #1;
      check("async_pc", pc_out, 32'h00);
      check("async_pend", redirect_pending, 0);
      reset_n = 1'b1;
      stall = 1'b0;
      check("post_rst_pc", pc_out, 32'h00);
      @(negedge clk);
      check("post_rst_cnt", pc_out, 32'h04);
      check("post_rst_taken", redirect_taken, 0);

      // misaligned redirect target
      set_src(0, 8'h22);
      src_valid = 4'b0001;
      @(negedge clk);
      check("mis_pc", pc_out, 32'h22);
      check("mis_err", misalign_err, ERR_ON);
      src_valid = '0;
      repeat (3) @(negedge clk);
      check("mis_sticky", misalign_err, ERR_ON);

      // randomized traffic, scoreboard does the checking
      repeat (1500) begin
         @(negedge clk);
         stall = ($urandom_range(0, 2) == 0);
         src_valid = ($urandom_range(0, 1) == 1) ? NS'($urandom) : '0;
         for (int i = 0; i < NS; i++) begin
            logic [AW-1:0] t;
            t = AW'($urandom);
            if ($urandom_range(0, 3) != 0) t[1:0] = 2'b00;
            set_src(i, t);
         end
         if ($urandom_range(0, 199) == 0) begin
            #2 reset_n = 1'b0;
            #1 reset_n = 1'b1;
         end
      end
      @(negedge clk);
      chk_en = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
